// File: rtl/lane_mem_sequencer.sv
// Serialises per-lane load/store requests onto a single-port data memory.
// Loads are coalesced across lanes that share an address.
module lane_mem_sequencer #(
  parameter int NUM_LANES = 16,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_is_store,
  input  logic [NUM_LANES-1:0]          active_mask,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_wdata,
  output logic [NUM_LANES*DATA_W-1:0]   lane_rdata,
  output logic                          stall,
  output logic                          done,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [CNT_W-1:0]              last_access_count
);

  localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_next;
  logic                  is_store;
  logic [NUM_LANES-1:0]  pending, pending_next, match;
  logic [ADDR_W-1:0]     addr_q  [NUM_LANES];
  logic [DATA_W-1:0]     wdata_q [NUM_LANES];
  logic [DATA_W-1:0]     rdata_q [NUM_LANES];
  logic [CNT_W-1:0]      access_count;
  logic [LIDX_W-1:0]     leader;
  logic                  accept, zero_req, final_access;

  // Priority encoder: lowest-index pending lane leads the access.
  always_comb begin
    leader = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        leader = LIDX_W'(i);
      end else begin
        leader = leader;
      end
    end
  end

  // Next-state and memory-side outputs; everything is held at zero while reset is high.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    match        = '0;
    stall        = 1'b0;
    done         = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    accept       = 1'b0;
    zero_req     = 1'b0;
    final_access = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid && (active_mask != '0)) begin
            accept       = 1'b1;
            stall        = 1'b1;
            pending_next = active_mask;
            state_next   = BUSY;
          end else if (req_valid) begin
            zero_req = 1'b1;
            done     = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        BUSY: begin
          mem_addr = addr_q[leader];
          if (is_store) begin
            mem_we               = 1'b1;
            mem_wdata            = wdata_q[leader];
            pending_next[leader] = 1'b0;
          end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
              match[i] = pending[i] && (addr_q[i] == mem_addr);
            end
            pending_next = pending & ~match;
          end
          if (pending_next == '0) begin
            final_access = 1'b1;
            done         = 1'b1;
            state_next   = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          pending_next = '0;
        end
      endcase
    end else begin
      state_next   = IDLE;
      pending_next = '0;
    end
  end

  // Final-cycle bypass lets the core see load data while done is high.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_rdata
    assign lane_rdata[g*DATA_W +: DATA_W] = match[g] ? mem_rdata : rdata_q[g];
  end

  // State, request capture, load results and access accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pending           <= '0;
      is_store          <= 1'b0;
      access_count      <= '0;
      last_access_count <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (accept) begin
        is_store     <= req_is_store;
        access_count <= '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          addr_q[i]  <= lane_addr[i*ADDR_W +: ADDR_W];
          wdata_q[i] <= lane_wdata[i*DATA_W +: DATA_W];
        end
      end else if (state == BUSY) begin
        access_count <= access_count + CNT_W'(1);
      end
      if (final_access) begin
        last_access_count <= access_count + CNT_W'(1);
      end else if (zero_req) begin
        last_access_count <= '0;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (match[i]) begin
          rdata_q[i] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_mem_sequencer.sv
// Bench for lane_mem_sequencer: table vectors, random requests against a
// request-level reference model, and a reset-during-store sequence.
module tb_lane_mem_sequencer;

  localparam int N = 16;

  typedef logic [15:0] vec_t [N];
  typedef struct {
    bit          st;
    logic [15:0] mask;
    logic [15:0] base;
    logic [15:0] stride;
    logic [15:0] dbase;
    int          exp_k;
  } vec_rec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_is_store;
  logic [N-1:0]   active_mask;
  logic [N*16-1:0] lane_addr;
  logic [N*16-1:0] lane_wdata;
  logic [N*16-1:0] lane_rdata;
  logic           stall, done, mem_we;
  logic [15:0]    mem_addr, mem_wdata, mem_rdata;
  logic [4:0]     last_access_count;

  int checks = 0;
  int errors = 0;

  bit [15:0] mem_arr [65536];
  bit        written [65536];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_rd [N];

  lane_mem_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .active_mask(active_mask), .lane_addr(lane_addr), .lane_wdata(lane_wdata),
    .lane_rdata(lane_rdata), .stall(stall), .done(done), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .last_access_count(last_access_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a < 16'd16) return 16'h0100 + a;
    if (a == 16'h0020) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] dut_mem(input logic [15:0] a);
    return written[a] ? mem_arr[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  always_comb mem_rdata = dut_mem(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name);
    for (int i = 0; i < N; i++) check(name, lane_rdata[i*16 +: 16], exp_rd[i]);
  endtask

  task automatic check_idle();
    check("idle_stall", stall, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_we", mem_we, 1'b0);
    check("idle_addr", mem_addr, 16'h0);
    check("idle_wdata", mem_wdata, 16'h0);
  endtask

  // One complete request: model the outcome, drive it, and check every cycle.
  task automatic run_req(input bit st, input logic [15:0] mask, input vec_t a, input vec_t d,
                         input int exp_k);
    logic [15:0] wr_a [$];
    logic [15:0] wr_d [$];
    logic [15:0] seen [$];
    int k, tgt, c, done_cyc, nw;
    bit found;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (st) begin
          wr_a.push_back(a[i]);
          wr_d.push_back(d[i]);
        end else begin
          found = 1'b0;
          foreach (seen[j]) if (seen[j] == a[i]) found = 1'b1;
          if (!found) seen.push_back(a[i]);
          exp_rd[i] = ref_read(a[i]);
        end
      end
    end
    k   = st ? wr_a.size() : seen.size();
    tgt = (exp_k >= 0) ? exp_k : k;

    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_is_store = st;
    active_mask  = mask;
    for (int i = 0; i < N; i++) begin
      lane_addr[i*16 +: 16]  = a[i];
      lane_wdata[i*16 +: 16] = d[i];
    end
    @(negedge clk);
    check("c0_we", mem_we, 1'b0);
    check("c0_stall", stall, (tgt == 0) ? 1'b0 : 1'b1);
    check("c0_done", done, (tgt == 0) ? 1'b1 : 1'b0);
    if (tgt > 0) begin
      c = 0; done_cyc = -1; nw = 0;
      while (done_cyc < 0 && c < 40) begin
        @(posedge clk); c++;
        @(negedge clk);
        if (mem_we) begin
          if (nw < wr_a.size()) begin
            check("wr_addr", mem_addr, wr_a[nw]);
            check("wr_data", mem_wdata, wr_d[nw]);
            ref_mem[wr_a[nw]] = wr_d[nw];
          end else begin
            check("extra_write", nw, wr_a.size());
          end
          nw++;
        end
        if (done) done_cyc = c;
        else check("busy_stall", stall, 1'b1);
      end
      check("done_cycle", done_cyc, tgt);
      check("done_stall", stall, 1'b0);
      check("write_count", nw, wr_a.size());
      check_lanes("done_rdata");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_idle();
    check("last_count", last_access_count, tgt);
    check_lanes("held_rdata");
    foreach (wr_a[j]) check("mem_content", dut_mem(wr_a[j]), ref_read(wr_a[j]));
  endtask

  vec_rec_t tbl [8];

  initial begin
    vec_t a, d;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; active_mask = '0;
    lane_addr = '0; lane_wdata = '0;
    for (int i = 0; i < N; i++) exp_rd[i] = 16'h0;

    tbl[0] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1, 16'h0000, 16};
    tbl[1] = '{1'b0, 16'hFFFF, 16'h0020, 16'h0, 16'h0000, 1};
    tbl[2] = '{1'b1, 16'h00A5, 16'h0040, 16'h1, 16'hA000, 4};
    tbl[3] = '{1'b1, 16'h0009, 16'h0010, 16'h0, 16'h5000, 2};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h1, 16'h0000, 0};
    tbl[5] = '{1'b0, 16'h0009, 16'h0010, 16'h0, 16'h0000, 1};
    tbl[6] = '{1'b1, 16'hFFFF, 16'h0080, 16'h0, 16'h7000, 16};
    tbl[7] = '{1'b0, 16'h8000, 16'h0080, 16'h0, 16'h0000, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle();
    check("rst_last_count", last_access_count, 5'd0);
    check_lanes("rst_rdata");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = tbl[t].base + 16'(i) * tbl[t].stride;
        d[i] = tbl[t].dbase + 16'(i);
      end
      run_req(tbl[t].st, tbl[t].mask, a, d, tbl[t].exp_k);
    end
    check("mem_10_lane3", dut_mem(16'h0010), 16'h5003);
    check("untouched_41", dut_mem(16'h0041), init_val(16'h0041));
    check("untouched_43", dut_mem(16'h0043), init_val(16'h0043));

    for (int r = 0; r < 25; r++) begin
      int sel;
      logic [15:0] m;
      sel = $urandom_range(0, 7);
      m = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i] = 16'h0200 + 16'($urandom_range(0, 5));
        d[i] = 16'($urandom);
      end
      run_req(1'($urandom_range(0, 1)), m, a, d, -1);
    end

    // Reset lands in the third access cycle of a full-mask store.
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = 1'b1; active_mask = 16'hFFFF;
    for (int i = 0; i < N; i++) begin
      lane_addr[i*16 +: 16]  = 16'h0400 + 16'(i);
      lane_wdata[i*16 +: 16] = 16'hC000 + 16'(i);
    end
    @(negedge clk);
    check("rs_c0_stall", stall, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); @(negedge clk);
      check("rs_we", mem_we, 1'b1);
      check("rs_addr", mem_addr, 16'h0400 + 16'(c - 1));
      check("rs_data", mem_wdata, 16'hC000 + 16'(c - 1));
      ref_mem[16'h0400 + 16'(c - 1)] = 16'hC000 + 16'(c - 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < N; i++) exp_rd[i] = 16'h0;
    @(negedge clk);
    check_idle();
    check("rs_last_count", last_access_count, 5'd0);
    check_lanes("rs_rdata");
    check("rs_mem_401", dut_mem(16'h0401), 16'hC001);
    check("rs_mem_402", dut_mem(16'h0402), init_val(16'h0402));
    for (int i = 0; i < N; i++) begin
      a[i] = 16'h0400 + 16'(i);
      d[i] = 16'h0;
    end
    run_req(1'b0, 16'hFFFF, a, d, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
